// File: rtl/fecg_pkg.sv
// Shared types and constants for the ECG whitening chain.
//   sample_t   : one signed 32-bit channel sample
//   wr_state_t : write-side FSM of the frame buffer (FILL, STALL)
//   SIZE_A_DEF / SIZE_B_DEF : default channel count / samples per frame
package fecg_pkg;

  localparam int SIZE_A_DEF = 8;
  localparam int SIZE_B_DEF = 8;

  typedef logic signed [31:0] sample_t;

  typedef enum logic {
    FILL  = 1'b0,
    STALL = 1'b1
  } wr_state_t;

endpackage

// File: rtl/ecg_frame_bank.sv
// One SIZE_A x SIZE_B register bank holding a single ECG frame.
// Ports:
//   clk  : clock
//   clr  : synchronous clear of the whole bank (highest priority)
//   we   : write enable for one column
//   col  : column index written when we=1
//   data : column data, data[i] is channel i
//   mat  : bank contents, mat[i][j] is channel i, sample j
module ecg_frame_bank
  import fecg_pkg::*;
#(
  parameter int SIZE_A = SIZE_A_DEF,
  parameter int SIZE_B = SIZE_B_DEF,
  parameter int COL_W  = (SIZE_B > 1) ? $clog2(SIZE_B) : 1
) (
  input  logic                                  clk,
  input  logic                                  clr,
  input  logic                                  we,
  input  logic    [COL_W-1:0]                   col,
  input  sample_t [SIZE_A-1:0]                  data,
  output sample_t [SIZE_A-1:0][SIZE_B-1:0]      mat
);

  always_ff @(posedge clk) begin
    if (clr) begin
      mat <= '0;
    end else if (we) begin
      for (int i = 0; i < SIZE_A; i++) begin
        mat[i][col] <= data[i];
      end
    end
  end

endmodule

// File: rtl/ecg_frame_buffer.sv
// Ping-pong frame buffer in front of the whitening pipeline. Columns of
// SIZE_A channel samples are collected into one bank while the other bank
// is presented on mat_out until downstream acknowledges it.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   in_valid    : in_sample holds a valid column
//   in_ready    : a column is accepted this cycle if in_valid is also high
//   in_sample   : one sample per channel
//   mat_out     : presented frame, mat_out[i][j] = channel i, sample j
//   frame_valid : mat_out holds a complete frame (level until ack)
//   frame_ack   : downstream is done with mat_out
//   frame_count : frames delivered since reset, wrapping
//
// state | meaning
// FILL  | write bank accepting columns
// STALL | write bank full, waiting for ack to swap
module ecg_frame_buffer
  import fecg_pkg::*;
#(
  parameter int SIZE_A = SIZE_A_DEF,
  parameter int SIZE_B = SIZE_B_DEF,
  parameter int CNT_W  = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  sample_t [SIZE_A-1:0]                  in_sample,
  output sample_t [SIZE_A-1:0][SIZE_B-1:0]      mat_out,
  output logic                                  frame_valid,
  input  logic                                  frame_ack,
  output logic    [CNT_W-1:0]                   frame_count
);

  localparam int COL_W = (SIZE_B > 1) ? $clog2(SIZE_B) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(SIZE_B - 1);

  wr_state_t         state_q, state_d;
  logic [COL_W-1:0]  wr_col;
  logic              wr_sel, rd_sel;
  logic              accept, last_col, swap, drop;

  sample_t [SIZE_A-1:0][SIZE_B-1:0] mat0, mat1;

  assign accept   = in_valid && in_ready;
  assign last_col = (wr_col == LAST_COL);

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    swap     = 1'b0;
    unique case (state_q)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && last_col) begin
          if (!frame_valid || frame_ack) swap = 1'b1;
          else                           state_d = STALL;
        end
      end
      STALL: begin
        // frame_valid is always 1 here, so ack alone releases the full bank
        if (frame_ack) begin
          swap    = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign drop = frame_ack && frame_valid && !swap;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      wr_col      <= '0;
      wr_sel      <= 1'b0;
      rd_sel      <= 1'b1;
      frame_valid <= 1'b0;
      frame_count <= '0;
    end else begin
      state_q <= state_d;
      if (swap) begin
        wr_col      <= '0;
        wr_sel      <= ~wr_sel;
        rd_sel      <= wr_sel;
        frame_valid <= 1'b1;
        frame_count <= frame_count + 1'b1;
      end else begin
        if (accept && !last_col) wr_col <= wr_col + 1'b1;
        if (drop)                frame_valid <= 1'b0;
      end
    end
  end

  // rd_sel always differs from wr_sel, so the presented bank is never written
  ecg_frame_bank #(.SIZE_A(SIZE_A), .SIZE_B(SIZE_B), .COL_W(COL_W)) u_bank0 (
    .clk  (clk),
    .clr  (rst),
    .we   (accept && !wr_sel),
    .col  (wr_col),
    .data (in_sample),
    .mat  (mat0)
  );

  ecg_frame_bank #(.SIZE_A(SIZE_A), .SIZE_B(SIZE_B), .COL_W(COL_W)) u_bank1 (
    .clk  (clk),
    .clr  (rst),
    .we   (accept && wr_sel),
    .col  (wr_col),
    .data (in_sample),
    .mat  (mat1)
  );

  assign mat_out = rd_sel ? mat1 : mat0;

endmodule
